// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the fetch sequencer.
//   - fetch_state_t : FSM state encoding (IDLE, FETCH, HALT, FAULT)
//   - PC_W_DEF, IRQ_VEC_DEF, MAX_WAIT_DEF : default parameter values
//   - STEP_W : width of the instruction length / PC step fields
package pc_ctrl_pkg;

  localparam int         PC_W_DEF     = 8;
  localparam logic [7:0] IRQ_VEC_DEF  = 8'hF0;
  localparam int         MAX_WAIT_DEF = 15;
  localparam int         STEP_W       = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_timer.sv
// pc_fetch_timer: counts fetch wait cycles and flags when the limit is hit.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clr           restart the count (not fetching, or ack seen)
//   inc           one more cycle spent waiting for an ack
//   expired       count has reached MAX_WAIT
module pc_fetch_timer
  import pc_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign expired = (wait_cnt == CNT_W'(MAX_WAIT));

  // Holding at the limit keeps the counter from wrapping if the owner
  // is slow to act on expired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer driving the PC register controls and the
// instruction-memory request handshake. Handles fetch wait, branch redirect,
// single-level interrupt entry/return (saved return address in epc), halt,
// and an optional fetch-timeout fault enabled by the PCCTRL_TIMEOUT_EN macro.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, halt_req       begin fetching / stop after the current fetch
//   pc_in                 current PC value from the PC register
//   mem_req, mem_addr     fetch request and address (mem_addr = pc_in)
//   mem_ack, instr_len    fetch done pulse and fetched instruction length
//   br_valid, br_target   taken branch and its target (with mem_ack)
//   irq, iret             interrupt request level / return (with mem_ack)
//   pc_enable, pc_hold, pc_load, pc_load_value, pc_step   PC controls
//   busy, in_isr, fault   status
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] IRQ_VEC  = PC_W'(IRQ_VEC_DEF),
  parameter int              MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic [PC_W-1:0]   pc_in,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [STEP_W-1:0] instr_len,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  input  logic              irq,
  input  logic              iret,
  output logic              pc_enable,
  output logic              pc_hold,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_value,
  output logic [STEP_W-1:0] pc_step,
  output logic              busy,
  output logic              in_isr,
  output logic              fault
);

  fetch_state_t      state, next_state;
  logic [PC_W-1:0]   epc;
  logic              halt_pend;
  logic              timeout;
  logic              irq_take;
  logic              iret_take;
  logic [STEP_W-1:0] step;
  logic [PC_W-1:0]   seq_pc;

  // A zero length would stall the PC, so it advances by one instead.
  assign step   = (instr_len == '0) ? STEP_W'(1) : instr_len;
  assign seq_pc = pc_in + PC_W'(step);

  // The address bus is forced low during reset so every output reads 0.
  assign mem_addr = reset_n ? pc_in : '0;

`ifdef PCCTRL_TIMEOUT_EN
  logic timer_expired;

  pc_fetch_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state != S_FETCH) || mem_ack),
    .inc     ((state == S_FETCH) && !mem_ack),
    .expired (timer_expired)
  );

  // An ack on the limit cycle takes priority over the timeout.
  assign timeout = timer_expired && !mem_ack;
`else
  // No counter is built; a valid (non-negative) MAX_WAIT keeps this at 0.
  assign timeout = (MAX_WAIT < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_isr    <= 1'b0;
      epc       <= '0;
      halt_pend <= 1'b0;
    end else begin
      if (irq_take) begin
        in_isr <= 1'b1;
        epc    <= br_valid ? br_target : seq_pc;
      end else if (iret_take) begin
        in_isr <= 1'b0;
      end
      // Remembers a halt request seen during the wait until the ack arrives.
      if ((state == S_FETCH) && !mem_ack) begin
        halt_pend <= halt_pend | halt_req;
      end else begin
        halt_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    pc_enable     = 1'b0;
    pc_hold       = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    pc_step       = '0;
    busy          = 1'b0;
    fault         = 1'b0;
    irq_take      = 1'b0;
    iret_take     = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        pc_enable = 1'b1;
        busy      = 1'b1;
        if (mem_ack) begin
          // Next-PC priority: interrupt entry, branch, interrupt return, step.
          if (irq && !in_isr) begin
            irq_take      = 1'b1;
            pc_load       = 1'b1;
            pc_load_value = IRQ_VEC;
          end else if (br_valid) begin
            pc_load       = 1'b1;
            pc_load_value = br_target;
          end else if (iret && in_isr) begin
            iret_take     = 1'b1;
            pc_load       = 1'b1;
            pc_load_value = epc;
          end else begin
            pc_step = step;
          end
          next_state = (halt_pend || halt_req) ? S_HALT : S_FETCH;
        end else begin
          pc_hold = 1'b1;
          if (timeout) next_state = S_FAULT;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_pc_fetch_ctrl;

  localparam int         PC_W     = 8;
  localparam logic [7:0] IRQ_VEC  = 8'hF0;
  localparam int         MAX_WAIT = 15;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, halt_req = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [2:0] instr_len = 3'd0;
  logic       br_valid = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic       irq = 1'b0, iret = 1'b0;
  logic       pc_enable, pc_hold, pc_load;
  logic [7:0] pc_load_value;
  logic [2:0] pc_step;
  logic       busy, in_isr, fault;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .PC_W     (PC_W),
    .IRQ_VEC  (IRQ_VEC),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .halt_req      (halt_req),
    .pc_in         (pc_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .instr_len     (instr_len),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .irq           (irq),
    .iret          (iret),
    .pc_enable     (pc_enable),
    .pc_hold       (pc_hold),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .pc_step       (pc_step),
    .busy          (busy),
    .in_isr        (in_isr),
    .fault         (fault)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state; pc is the PC register the model owns.
  int       m_st;
  bit       m_isr;
  bit [7:0] m_epc;
  bit [7:0] pc;
  bit       m_halt;
  int       m_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_isr = 0; m_epc = 8'h00; m_halt = 0; m_wait = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pc_enable", pc_enable, 0);
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_load_value", pc_load_value, 0);
    chk("rst_pc_step", pc_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_fault", fault, 0);
    model_reset();
    start = 0; halt_req = 0; mem_ack = 0; br_valid = 0; irq = 0; iret = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model to the state after the coming rising edge.
  task automatic cycle(input bit st, input bit hr, input bit ack, input bit [2:0] len,
                       input bit br, input bit [7:0] tgt, input bit iq, input bit ir);
    bit [7:0] s;
    bit       e_req, e_en, e_hold, e_load, e_busy, e_fault;
    bit [7:0] e_lv;
    bit [2:0] e_step;
    @(negedge clk);
    start = st; halt_req = hr; mem_ack = ack; instr_len = len;
    br_valid = br; br_target = tgt; irq = iq; iret = ir; pc_in = pc;
    #1;
    s = (len == 0) ? 8'd1 : 8'(len);
    e_req = 0; e_en = 0; e_hold = 0; e_load = 0; e_busy = 0; e_fault = 0;
    e_lv = 8'h00; e_step = 3'd0;
    if (m_st == M_FETCH) begin
      e_req = 1; e_en = 1; e_busy = 1;
      if (ack) begin
        if (iq && !m_isr)       begin e_load = 1; e_lv = IRQ_VEC; end
        else if (br)            begin e_load = 1; e_lv = tgt; end
        else if (ir && m_isr)   begin e_load = 1; e_lv = m_epc; end
        else                    e_step = s[2:0];
      end else begin
        e_hold = 1;
      end
    end
    if (m_st == M_FAULT) e_fault = 1;

    chk("mem_req", mem_req, e_req);
    chk("mem_addr", mem_addr, pc);
    chk("pc_enable", pc_enable, e_en);
    chk("pc_hold", pc_hold, e_hold);
    chk("pc_load", pc_load, e_load);
    chk("pc_load_value", pc_load_value, e_lv);
    chk("pc_step", pc_step, e_step);
    chk("busy", busy, e_busy);
    chk("in_isr", in_isr, m_isr);
    chk("fault", fault, e_fault);

    case (m_st)
      M_IDLE, M_HALT: if (st) begin m_st = M_FETCH; m_wait = 0; m_halt = 0; end
      M_FETCH: begin
        if (ack) begin
          if (iq && !m_isr) begin
            m_epc = br ? tgt : pc + s;
            m_isr = 1;
          end else if (!br && ir && m_isr) begin
            m_isr = 0;
          end
          pc = e_load ? e_lv : pc + s;
          m_st = (m_halt || hr) ? M_HALT : M_FETCH;
          m_halt = 0;
          m_wait = 0;
        end else begin
          m_halt = m_halt | hr;
`ifdef PCCTRL_TIMEOUT_EN
          if (m_wait == MAX_WAIT) m_st = M_FAULT;
          else m_wait++;
`endif
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    pc = 8'h10;
    do_reset();

    // 1: start, two wait cycles, ack with length 2
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_hold", pc_hold, 1);
    chk("t1_addr", mem_addr, 8'h10);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3'd2, 0, 0, 0, 0);
    chk("t1_step", pc_step, 3'd2);
    chk("t1_busy", busy, 1);

    // 2: irq beats a simultaneous branch, then iret returns to the branch target
    pc = 8'h20;
    cycle(0, 0, 1, 3'd1, 1, 8'h40, 1, 0);
    chk("t2_irq_vec", pc_load_value, 8'hF0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_in_isr", in_isr, 1);
    cycle(0, 0, 1, 3'd3, 0, 0, 1, 0);
    cycle(0, 0, 1, 3'd1, 0, 0, 0, 1);
    chk("t2_epc", pc_load_value, 8'h40);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_in_isr_clr", in_isr, 0);

    // 3: wrap at the top of the address space, zero length steps by one
    pc = 8'hFF;
    cycle(0, 0, 1, 3'd1, 0, 0, 0, 0);
    chk("t3_step", pc_step, 3'd1);
    cycle(0, 0, 1, 3'd0, 0, 0, 0, 0);
    chk("t3_addr_wrap", mem_addr, 8'h00);
    chk("t3_len0", pc_step, 3'd1);

    // 4: halt pulsed mid-wait, then restart
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3'd2, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t4_halted", mem_req, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_resume", mem_req, 1);

    // 5: no ack for a long time
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PCCTRL_TIMEOUT_EN
    chk("t5_fault", fault, 1);
    chk("t5_req", mem_req, 0);
`else
    chk("t5_nofault", fault, 0);
    chk("t5_waiting", mem_req, 1);
`endif
    do_reset();

    // 6: reset during a wait inside an ISR
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3'd1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_in_isr", in_isr, 1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_idle", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      if ($urandom_range(49) == 0) pc = 8'($urandom);
      cycle($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0,
            3'($urandom), $urandom_range(3) == 0, 8'($urandom),
            $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
